axi4lite_reg_slave: RTL and testbench

// - Synthesizable AXI4-Lite slave register file.
// - Sits directly downstream of the AXI4Lite interface.
// - Replaces the behavioural slave BFM when a real register target is needed behind the Axi4LiteMaster BFM.
// - Exposes R registers of N bytes each as flat outputs, plus one write-commit pulse per register.

---
 rtl/axi4lite_pkg.sv | 12 +
 rtl/axi4lite_reg_slave_if.sv | 39 +++
 rtl/axil_hold_reg.sv | 42 ++++
 rtl/axi4lite_reg_slave.sv | 173 +++++++++++++++++
 tb/tb_axi4lite_reg_slave.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions used by the register slave and its bus models.
package axi4lite_pkg;

  // AXI response codes
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a master and the register slave.
interface axi4lite_reg_slave_if
  import axi4lite_pkg::*;
#(
  parameter int N = 4,
  parameter int A = 32
);
  logic [A-1:0]   AWADDR;
  logic [2:0]     AWPROT;
  logic           AWVALID;
  logic           AWREADY;
  logic [8*N-1:0] WDATA;
  logic [N-1:0]   WSTRB;
  logic           WVALID;
  logic           WREADY;
  resp_t          BRESP;
  logic           BVALID;
  logic           BREADY;
  logic [A-1:0]   ARADDR;
  logic [2:0]     ARPROT;
  logic           ARVALID;
  logic           ARREADY;
  logic [8*N-1:0] RDATA;
  resp_t          RRESP;
  logic           RVALID;
  logic           RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready capture register. o_full/o_data see an incoming beat
// in its accept cycle, so a consumer can use it with zero added latency.
module axil_hold_reg #(
  parameter int W = 8
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_clr,
  output logic         o_ready,
  output logic         o_full,
  output logic [W-1:0] o_data
);
  logic         r_act;
  logic         r_full;
  logic [W-1:0] r_data;
  logic         w_take;

  // ready stays low until the first clock after reset release
  assign o_ready = r_act && !r_full;
  assign w_take  = i_valid && o_ready;
  assign o_full  = r_full || w_take;
  assign o_data  = r_full ? r_data : i_data;

  // hold state: cleared when consumed, otherwise filled on handshake
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_act  <= 1'b0;
      r_full <= 1'b0;
      r_data <= {W{1'b0}};
    end else begin
      r_act <= 1'b1;
      if (i_clr) begin
        r_full <= 1'b0;
      end else if (w_take) begin
        r_full <= 1'b1;
        r_data <= i_data;
      end
    end
  end
endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register file slave: R registers of N bytes, flat register
// outputs and a one-cycle write-commit pulse per register.
// Optional macro AXIL_REG_SLVERR_EN: out-of-range accesses answer SLVERR
// instead of OKAY.
module axi4lite_reg_slave
  import axi4lite_pkg::*;
#(
  parameter int             N      = 4,
  parameter int             A      = 32,
  parameter int             R      = 8,
  parameter logic [8*N-1:0] RSTVAL = {(8*N){1'b0}}
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi4lite_reg_slave_if.slave  s_axi,
  output logic [R*8*N-1:0]     reg_o,
  output logic [R-1:0]         wr_pulse_o
);
  localparam int DW = 8 * N;
  localparam int SH = $clog2(N);

  logic [DW-1:0]   r_regs [R];
  logic [R-1:0]    r_wr_pulse;
  logic            r_bvalid;
  resp_t           r_bresp;
  logic            r_ar_act;
  logic            r_rvalid;
  logic [DW-1:0]   r_rdata;
  resp_t           r_rresp;

  logic            w_aw_full;
  logic            w_w_full;
  logic [A-1:0]    w_aw_addr;
  logic [DW+N-1:0] w_w_bundle;
  logic [DW-1:0]   w_wdata;
  logic [N-1:0]    w_wstrb;
  logic            w_commit;
  logic [A-1:0]    w_wr_idx;
  logic            w_wr_hit;
  logic            w_wr_en;
  logic            w_ar_ready;
  logic            w_ar_hs;
  logic [A-1:0]    w_rd_idx;
  logic            w_rd_hit;
  logic [DW-1:0]   w_rd_data;
  resp_t           w_bresp;
  resp_t           w_rresp;

  axil_hold_reg #(.W(A)) u_aw_hold (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .i_valid (s_axi.AWVALID),
    .i_data  (s_axi.AWADDR),
    .i_clr   (w_commit),
    .o_ready (s_axi.AWREADY),
    .o_full  (w_aw_full),
    .o_data  (w_aw_addr)
  );

  axil_hold_reg #(.W(DW + N)) u_w_hold (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .i_valid (s_axi.WVALID),
    .i_data  ({s_axi.WSTRB, s_axi.WDATA}),
    .i_clr   (w_commit),
    .o_ready (s_axi.WREADY),
    .o_full  (w_w_full),
    .o_data  (w_w_bundle)
  );

  assign w_wdata  = w_w_bundle[DW-1:0];
  assign w_wstrb  = w_w_bundle[DW+N-1:DW];
  // a write retires only when its response slot is free or draining now
  assign w_commit = w_aw_full && w_w_full && (!r_bvalid || s_axi.BREADY);
  assign w_wr_idx = w_aw_addr >> SH;
  assign w_wr_hit = (w_wr_idx < A'(R));
  assign w_wr_en  = w_commit && w_wr_hit;

  assign w_ar_ready = r_ar_act && (!r_rvalid || s_axi.RREADY);
  assign w_ar_hs    = s_axi.ARVALID && w_ar_ready;
  assign w_rd_idx   = s_axi.ARADDR >> SH;
  assign w_rd_hit   = (w_rd_idx < A'(R));

  // read mux; out-of-range addresses select nothing and return zero
  always_comb begin
    w_rd_data = {DW{1'b0}};
    for (int r = 0; r < R; r++) begin
      w_rd_data = w_rd_data |
                  ((w_rd_hit && (w_rd_idx == A'(r))) ? r_regs[r] : {DW{1'b0}});
    end
  end

  // response codes for the write commit and the read handshake
  always_comb begin
    w_bresp = OKAY;
    w_rresp = OKAY;
`ifdef AXIL_REG_SLVERR_EN
    if (!w_wr_hit) begin
      w_bresp = SLVERR;
    end else begin
      w_bresp = OKAY;
    end
    if (!w_rd_hit) begin
      w_rresp = SLVERR;
    end else begin
      w_rresp = OKAY;
    end
`endif
  end

  // register array byte-enable update and commit pulse
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int r = 0; r < R; r++) begin
        r_regs[r] <= RSTVAL;
      end
      r_wr_pulse <= {R{1'b0}};
    end else begin
      for (int r = 0; r < R; r++) begin
        r_wr_pulse[r] <= w_wr_en && (w_wr_idx == A'(r));
        for (int b = 0; b < N; b++) begin
          if (w_wr_en && (w_wr_idx == A'(r)) && w_wstrb[b]) begin
            r_regs[r][8*b +: 8] <= w_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // write response: raised by a commit, held until BREADY
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_bvalid <= 1'b0;
      r_bresp  <= OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_bresp;
    end else if (s_axi.BREADY) begin
      r_bvalid <= 1'b0;
    end
  end

  // read response: registered on AR handshake, held until RREADY
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_ar_act <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= {DW{1'b0}};
      r_rresp  <= OKAY;
    end else begin
      r_ar_act <= 1'b1;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rresp;
      end else if (s_axi.RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.BRESP   = r_bresp;
  assign s_axi.ARREADY = w_ar_ready;
  assign s_axi.RVALID  = r_rvalid;
  assign s_axi.RDATA   = r_rdata;
  assign s_axi.RRESP   = r_rresp;
  assign wr_pulse_o    = r_wr_pulse;

  for (genvar g = 0; g < R; g++) begin : g_reg_out
    assign reg_o[g*DW +: DW] = r_regs[g];
  end
endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Self-checking bench for axi4lite_reg_slave against a behavioural register model.
module tb_axi4lite_reg_slave;
  import axi4lite_pkg::*;

  localparam int          N      = 4;
  localparam int          A      = 32;
  localparam int          R      = 72;
  localparam logic [31:0] RSTVAL = 32'hC3C3_0F0F;

  logic            ACLK    = 1'b0;
  logic            ARESETn = 1'b0;
  logic [R*32-1:0] reg_o;
  logic [R-1:0]    wr_pulse_o;

  axi4lite_reg_slave_if #(.N(N), .A(A)) bus ();

  axi4lite_reg_slave #(.N(N), .A(A), .R(R), .RSTVAL(RSTVAL)) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .s_axi      (bus.slave),
    .reg_o      (reg_o),
    .wr_pulse_o (wr_pulse_o)
  );

  always #5 ACLK = ~ACLK;

  int          n_pass   = 0;
  int          n_checks = 0;
  logic [31:0] m_regs [R];

  // ---------------- reference model ----------------
  function automatic bit in_rng(input logic [31:0] addr);
    return (addr / 4) < R;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] addr);
`ifdef AXIL_REG_SLVERR_EN
    return in_rng(addr) ? 2'b00 : 2'b10;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [R-1:0] exp_pulse(input logic [31:0] addr);
    logic [R-1:0] v;
    v = '0;
    if (in_rng(addr)) v[addr / 4] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    return in_rng(addr) ? m_regs[addr / 4] : 32'h0;
  endfunction

  function automatic logic [R*32-1:0] m_flat();
    logic [R*32-1:0] v;
    for (int r = 0; r < R; r++) v[r*32 +: 32] = m_regs[r];
    return v;
  endfunction

  task automatic m_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (in_rng(addr))
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_regs[addr / 4][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic m_reset();
    for (int r = 0; r < R; r++) m_regs[r] = RSTVAL;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle();
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
  endtask

  function automatic logic [31:0] rnd_in_addr();
    return 32'($urandom_range(2, R - 1)) * 32'd4 + 32'($urandom_range(0, 3));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    m_reset();
    #20;
    n_checks++; if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID} !== 5'b0)
      $display("FAIL reset_ctl: got %b expected 00000", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}); else n_pass++;
    n_checks++; if ({bus.BRESP, bus.RRESP, bus.RDATA} !== 36'h0)
      $display("FAIL reset_resp: got %h expected 0", {bus.BRESP, bus.RRESP, bus.RDATA}); else n_pass++;
    n_checks++; if (reg_o !== m_flat() || wr_pulse_o !== '0)
      $display("FAIL reset_regs: got reg0 %h pulse %h expected %h 0", reg_o[31:0], wr_pulse_o, RSTVAL); else n_pass++;
    #2 ARESETn = 1'b1;
    step(); step();
    n_checks++; if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111)
      $display("FAIL reset_release_ready: got %b expected 111", {bus.AWREADY, bus.WREADY, bus.ARREADY}); else n_pass++;
  endtask

  task automatic test_basic_write();
    bus.BREADY = 1'b1;
    bus.AWADDR = 32'h100; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h1234_5678; bus.WSTRB = 4'b1011; bus.WVALID = 1'b1;
    #1;
    n_checks++; if ({bus.AWREADY, bus.WREADY} !== 2'b11)
      $display("FAIL basic_ready: got %b expected 11", {bus.AWREADY, bus.WREADY}); else n_pass++;
    @(posedge ACLK); #1;
    idle();
    m_write(32'h100, 32'h1234_5678, 4'b1011);
    n_checks++; if (bus.BVALID !== 1'b1 || bus.BRESP !== 2'b00)
      $display("FAIL basic_b: got %b/%b expected 1/00", bus.BVALID, bus.BRESP); else n_pass++;
    n_checks++; if (wr_pulse_o !== exp_pulse(32'h100))
      $display("FAIL basic_pulse: got %h expected %h", wr_pulse_o, exp_pulse(32'h100)); else n_pass++;
    n_checks++; if (reg_o[64*32 +: 32] !== m_regs[64])
      $display("FAIL basic_reg64: got %h expected %h", reg_o[64*32 +: 32], m_regs[64]); else n_pass++;
    step();
    n_checks++; if (bus.BVALID !== 1'b0 || wr_pulse_o !== '0)
      $display("FAIL basic_after: got bvalid %b pulse %h expected 0 0", bus.BVALID, wr_pulse_o); else n_pass++;
  endtask

  task automatic test_w_before_aw();
    bus.BREADY = 1'b1;
    bus.WDATA = 32'hAABB_CCDD; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    #1;
    n_checks++; if (bus.WREADY !== 1'b1)
      $display("FAIL wfirst_wready: got %b expected 1", bus.WREADY); else n_pass++;
    @(posedge ACLK); #1;
    idle();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({bus.BVALID, bus.WREADY, |wr_pulse_o} !== 3'b000)
        $display("FAIL wfirst_wait%0d: got %b expected 000", i, {bus.BVALID, bus.WREADY, |wr_pulse_o}); else n_pass++;
      step();
    end
    bus.AWADDR = 32'h4; bus.AWVALID = 1'b1;
    #1;
    n_checks++; if (bus.AWREADY !== 1'b1)
      $display("FAIL wfirst_awready: got %b expected 1", bus.AWREADY); else n_pass++;
    @(posedge ACLK); #1;
    idle();
    m_write(32'h4, 32'hAABB_CCDD, 4'hF);
    n_checks++; if (bus.BVALID !== 1'b1 || wr_pulse_o !== exp_pulse(32'h4) || reg_o !== m_flat())
      $display("FAIL wfirst_commit: got bvalid %b pulse %h reg1 %h expected 1 %h %h",
               bus.BVALID, wr_pulse_o, reg_o[63:32], exp_pulse(32'h4), m_regs[1]); else n_pass++;
    step();
    n_checks++; if (bus.BVALID !== 1'b0)
      $display("FAIL wfirst_bclear: got %b expected 0", bus.BVALID); else n_pass++;
  endtask

  task automatic test_bready_stall();
    logic [31:0] a1, a2, d1, d2;
    logic [3:0]  s1;
    a1 = rnd_in_addr(); a2 = rnd_in_addr();
    d1 = $urandom; d2 = $urandom; s1 = 4'($urandom_range(0, 15));
    bus.BREADY = 1'b0;
    bus.AWADDR = a1; bus.AWVALID = 1'b1; bus.WDATA = d1; bus.WSTRB = s1; bus.WVALID = 1'b1;
    @(posedge ACLK); #1;
    m_write(a1, d1, s1);
    bus.AWADDR = a2; bus.WDATA = d2; bus.WSTRB = 4'hF;
    @(posedge ACLK); #1;
    idle();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY} !== {1'b1, exp_resp(a1), 2'b00}
                      || wr_pulse_o !== '0 || reg_o !== m_flat())
        $display("FAIL stall_hold%0d: got b %b resp %b rdy %b%b pulse %h expected 1 %b 00 0",
                 i, bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY, wr_pulse_o, exp_resp(a1)); else n_pass++;
      step();
    end
    bus.BREADY = 1'b1;
    @(posedge ACLK); #1;
    m_write(a2, d2, 4'hF);
    n_checks++; if (bus.BVALID !== 1'b1 || bus.BRESP !== exp_resp(a2) || wr_pulse_o !== exp_pulse(a2) || reg_o !== m_flat())
      $display("FAIL stall_release: got b %b pulse %h expected 1 %h", bus.BVALID, wr_pulse_o, exp_pulse(a2)); else n_pass++;
    n_checks++; if ({bus.AWREADY, bus.WREADY} !== 2'b11)
      $display("FAIL stall_ready_back: got %b expected 11", {bus.AWREADY, bus.WREADY}); else n_pass++;
    step();
    n_checks++; if (bus.BVALID !== 1'b0)
      $display("FAIL stall_bclear: got %b expected 0", bus.BVALID); else n_pass++;
  endtask

  task automatic test_read();
    logic [31:0] exp_d;
    exp_d = m_read(32'h4);
    bus.RREADY = 1'b0;
    bus.ARADDR = 32'h4; bus.ARVALID = 1'b1;
    #1;
    n_checks++; if (bus.ARREADY !== 1'b1)
      $display("FAIL read_arready: got %b expected 1", bus.ARREADY); else n_pass++;
    @(posedge ACLK); #1;
    idle();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({bus.RVALID, bus.ARREADY, bus.RRESP} !== 4'b1000 || bus.RDATA !== exp_d)
        $display("FAIL read_hold%0d: got v %b ar %b resp %b data %h expected 1 0 00 %h",
                 i, bus.RVALID, bus.ARREADY, bus.RRESP, bus.RDATA, exp_d); else n_pass++;
      step();
    end
    bus.RREADY = 1'b1;
    #1;
    n_checks++; if (bus.ARREADY !== 1'b1)
      $display("FAIL read_arready_rready: got %b expected 1", bus.ARREADY); else n_pass++;
    @(posedge ACLK); #1;
    n_checks++; if (bus.RVALID !== 1'b0)
      $display("FAIL read_rclear: got %b expected 0", bus.RVALID); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    d = $urandom;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    bus.AWADDR = 32'h1234_5678; bus.AWVALID = 1'b1; bus.WDATA = d; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(posedge ACLK); #1;
    idle();
    m_write(32'h1234_5678, d, 4'hF);
    n_checks++; if (bus.BVALID !== 1'b1 || bus.BRESP !== exp_resp(32'h1234_5678) || wr_pulse_o !== '0 || reg_o !== m_flat())
      $display("FAIL oor_write: got b %b resp %b pulse %h expected 1 %b 0", bus.BVALID, bus.BRESP, wr_pulse_o, exp_resp(32'h1234_5678)); else n_pass++;
    bus.ARADDR = 32'h1234_5678; bus.ARVALID = 1'b1;
    @(posedge ACLK); #1;
    idle();
    n_checks++; if (bus.RVALID !== 1'b1 || bus.RDATA !== 32'h0 || bus.RRESP !== exp_resp(32'h1234_5678))
      $display("FAIL oor_read: got v %b data %h resp %b expected 1 0 %b", bus.RVALID, bus.RDATA, bus.RRESP, exp_resp(32'h1234_5678)); else n_pass++;
    step();
  endtask

  task automatic test_same_cycle();
    logic [31:0] a, d, old_d;
    a = rnd_in_addr(); d = $urandom;
    old_d = m_read(a);
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    bus.AWADDR = a; bus.AWVALID = 1'b1; bus.WDATA = d; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = a; bus.ARVALID = 1'b1;
    @(posedge ACLK); #1;
    idle();
    m_write(a, d, 4'hF);
    n_checks++; if (bus.RDATA !== old_d || reg_o !== m_flat())
      $display("FAIL same_cycle: got rdata %h reg %h expected %h %h", bus.RDATA, reg_o[(a/4)*32 +: 32], old_d, m_regs[a/4]); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    bus.BREADY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a = rnd_in_addr(); d = $urandom;
      bus.AWADDR = a; bus.AWVALID = 1'b1; bus.WDATA = d; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      #1;
      n_checks++; if ({bus.AWREADY, bus.WREADY} !== 2'b11)
        $display("FAIL b2b_ready%0d: got %b expected 11", k, {bus.AWREADY, bus.WREADY}); else n_pass++;
      @(posedge ACLK); #1;
      m_write(a, d, 4'hF);
      n_checks++; if (bus.BVALID !== 1'b1 || wr_pulse_o !== exp_pulse(a) || reg_o !== m_flat())
        $display("FAIL b2b_commit%0d: got b %b pulse %h expected 1 %h", k, bus.BVALID, wr_pulse_o, exp_pulse(a)); else n_pass++;
    end
    idle();
    step();
    n_checks++; if (bus.BVALID !== 1'b0)
      $display("FAIL b2b_bclear: got %b expected 0", bus.BVALID); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0]  s;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    for (int k = 0; k < 30; k++) begin
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h8000_0000)
                                      : 32'($urandom_range(0, R - 1)) * 32'd4 + 32'($urandom_range(0, 3));
      d = $urandom; s = 4'($urandom_range(0, 15));
      bus.AWADDR = a; bus.AWVALID = 1'b1; bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
      @(posedge ACLK); #1;
      idle();
      m_write(a, d, s);
      n_checks++; if (bus.BVALID !== 1'b1 || bus.BRESP !== exp_resp(a) || wr_pulse_o !== exp_pulse(a) || reg_o !== m_flat())
        $display("FAIL rnd_write%0d: addr %h got b %b resp %b pulse %h expected 1 %b %h",
                 k, a, bus.BVALID, bus.BRESP, wr_pulse_o, exp_resp(a), exp_pulse(a)); else n_pass++;
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h8000_0000) : 32'($urandom_range(0, R - 1)) * 32'd4;
      bus.ARADDR = a; bus.ARVALID = 1'b1;
      @(posedge ACLK); #1;
      idle();
      n_checks++; if (bus.RVALID !== 1'b1 || bus.RDATA !== m_read(a) || bus.RRESP !== exp_resp(a))
        $display("FAIL rnd_read%0d: addr %h got %h/%b expected %h/%b", k, a, bus.RDATA, bus.RRESP, m_read(a), exp_resp(a)); else n_pass++;
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, d;
    bus.BREADY = 1'b0;
    bus.AWADDR = rnd_in_addr(); bus.AWVALID = 1'b1; bus.WDATA = $urandom; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(posedge ACLK); #1;
    idle();
    bus.WDATA = $urandom; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(posedge ACLK); #1;
    idle();
    n_checks++; if ({bus.BVALID, bus.WREADY} !== 2'b10)
      $display("FAIL rstmid_setup: got %b expected 10", {bus.BVALID, bus.WREADY}); else n_pass++;
    #2 ARESETn = 1'b0;
    #1;
    m_reset();
    n_checks++; if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID, bus.BRESP} !== 7'b0
                    || reg_o !== m_flat() || wr_pulse_o !== '0)
      $display("FAIL rstmid_async: got ctl %b reg0 %h pulse %h expected 0 %h 0",
               {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}, reg_o[31:0], wr_pulse_o, RSTVAL); else n_pass++;
    #2 ARESETn = 1'b1;
    bus.BREADY = 1'b1;
    step(); step();
    a = 32'hC; d = $urandom;
    bus.AWADDR = a; bus.AWVALID = 1'b1;
    @(posedge ACLK); #1;
    idle();
    n_checks++; if (bus.BVALID !== 1'b0 || wr_pulse_o !== '0 || reg_o !== m_flat())
      $display("FAIL rstmid_stale_w: got b %b pulse %h expected 0 0", bus.BVALID, wr_pulse_o); else n_pass++;
    bus.WDATA = d; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(posedge ACLK); #1;
    idle();
    m_write(a, d, 4'hF);
    n_checks++; if (bus.BVALID !== 1'b1 || bus.BRESP !== 2'b00 || wr_pulse_o !== exp_pulse(a) || reg_o !== m_flat())
      $display("FAIL rstmid_first_write: got b %b pulse %h reg3 %h expected 1 %h %h",
               bus.BVALID, wr_pulse_o, reg_o[127:96], exp_pulse(a), m_regs[3]); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_w_before_aw();
    test_bready_stall();
    test_read();
    test_out_of_range();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end
endmodule
